// File: rtl/seguidor_pkg.sv
// Shared types for the line follower: FSM state encoding, drive selection and default tuning.
package seguidor_pkg;

    typedef enum logic [1:0] {
        ST_STOP    = 2'd0,
        ST_FORWARD = 2'd1,
        ST_LEFT    = 2'd2,
        ST_RIGHT   = 2'd3
    } estado_t;

    typedef enum logic [1:0] {
        SEL_OFF  = 2'd0,
        SEL_TURN = 2'd1,
        SEL_FWD  = 2'd2
    } duty_sel_t;

    typedef struct packed {
        duty_sel_t sel_a;
        logic      in1;
        duty_sel_t sel_b;
        logic      in3;
    } drive_t;

    localparam int DEF_PWM_BITS     = 8;
    localparam int DEF_DUTY_FWD     = 200;
    localparam int DEF_DUTY_TURN    = 120;
    localparam int DEF_DEBOUNCE     = 4;
    localparam int DEF_STOP_CONFIRM = 16;

    // Motor A is the left wheel: turning left stops it and drives only the right wheel.
    function automatic drive_t drive_of(estado_t st);
        drive_t d;
        d = '{sel_a: SEL_OFF, in1: 1'b0, sel_b: SEL_OFF, in3: 1'b0};
        case (st)
            ST_FORWARD: d = '{sel_a: SEL_FWD,  in1: 1'b1, sel_b: SEL_FWD,  in3: 1'b1};
            ST_LEFT:    d = '{sel_a: SEL_OFF,  in1: 1'b0, sel_b: SEL_TURN, in3: 1'b1};
            ST_RIGHT:   d = '{sel_a: SEL_TURN, in1: 1'b1, sel_b: SEL_OFF,  in3: 1'b0};
            default:    d = '{sel_a: SEL_OFF,  in1: 1'b0, sel_b: SEL_OFF,  in3: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seguidor_linea_filter.sv
// Sensor conditioning: 2-FF synchronizer followed by a consecutive-sample debouncer.
module sensor_filter #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor,
    output logic filtered
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic          sync1, sync2;
    logic          filt_q;
    logic [CW-1:0] run_cnt;
    logic          mismatch, accept;

    assign mismatch = (sync2 != filt_q);
    assign accept   = mismatch && (run_cnt == CW'(DEBOUNCE - 1));

    // Exposes the value the filter register takes on the coming edge, so the
    // FSM updates on the same edge the debounce run completes.
    assign filtered = accept ? sync2 : filt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            filt_q  <= 1'b0;
            run_cnt <= '0;
        end else begin
            sync1  <= sensor;
            sync2  <= sync1;
            filt_q <= filtered;
            if (!mismatch || accept)
                run_cnt <= '0;
            else
                run_cnt <= run_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seguidor_linea.sv
// Two-sensor line follower: filtered sensors drive a 4-state FSM that selects
// per-motor PWM duty and direction for an L298-style dual H-bridge.
module seguidor_linea
    import seguidor_pkg::*;
#(
    parameter int PWM_BITS     = DEF_PWM_BITS,
    parameter int DUTY_FWD     = DEF_DUTY_FWD,
    parameter int DUTY_TURN    = DEF_DUTY_TURN,
    parameter int DEBOUNCE     = DEF_DEBOUNCE,
    parameter int STOP_CONFIRM = DEF_STOP_CONFIRM
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_izquierdo,
    input  logic sensor_derecho,
    output logic ENA,
    output logic IN1,
    output logic ENB,
    output logic IN3
);

    localparam int SW = $clog2(STOP_CONFIRM + 1);

    // Index 0 is the left sensor, index 1 the right one.
    logic [1:0] raw;
    logic [1:0] filt;

    assign raw = {sensor_derecho, sensor_izquierdo};

    for (genvar i = 0; i < 2; i++) begin : g_filt
        sensor_filter #(
            .DEBOUNCE (DEBOUNCE)
        ) u_filt (
            .clk      (clk),
            .reset    (reset),
            .sensor   (raw[i]),
            .filtered (filt[i])
        );
    end

    estado_t       state, state_nxt;
    logic [SW-1:0] stop_cnt;
    logic          both_on, confirmed;

    assign both_on   = &filt;
    assign confirmed = both_on && (stop_cnt >= SW'(STOP_CONFIRM - 1));

    // Counts consecutive (1,1) edges; saturates once STOP is confirmed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stop_cnt <= '0;
        else if (!both_on)
            stop_cnt <= '0;
        else if (!confirmed)
            stop_cnt <= stop_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_STOP;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (filt)
            2'b00:   state_nxt = ST_FORWARD;
            2'b01:   state_nxt = ST_LEFT;
            2'b10:   state_nxt = ST_RIGHT;
            default: state_nxt = confirmed ? ST_STOP : state;
        endcase
    end

    function automatic logic [PWM_BITS-1:0] duty_val(duty_sel_t s);
        case (s)
            SEL_FWD:  return PWM_BITS'(DUTY_FWD);
            SEL_TURN: return PWM_BITS'(DUTY_TURN);
            default:  return '0;
        endcase
    endfunction

    drive_t              drv;
    logic [PWM_BITS-1:0] duty_a, duty_b;
    logic [PWM_BITS-1:0] pwm_cnt;

    always_comb begin
        drv    = drive_of(state);
        duty_a = duty_val(drv.sel_a);
        duty_b = duty_val(drv.sel_b);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt <= '0;
            ENA     <= 1'b0;
            IN1     <= 1'b0;
            ENB     <= 1'b0;
            IN3     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            ENA     <= (pwm_cnt < duty_a);
            IN1     <= drv.in1;
            ENB     <= (pwm_cnt < duty_b);
            IN3     <= drv.in3;
        end
    end

endmodule

// File: tb/tb_seguidor_linea.sv
// Bench for seguidor_linea: cycle model of the sensor-to-motor behaviour plus directed checks.
module tb_seguidor_linea;

    localparam int D    = 4;
    localparam int SC   = 16;
    localparam int FWD  = 200;
    localparam int TURN = 120;

    localparam int M_STOP = 0, M_FWD = 1, M_LEFT = 2, M_RIGHT = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sl = 1'b0, sr = 1'b0;
    logic ENA, IN1, ENB, IN3;

    always #5 clk = ~clk;

    seguidor_linea dut (
        .clk              (clk),
        .reset            (reset),
        .sensor_izquierdo (sl),
        .sensor_derecho   (sr),
        .ENA              (ENA),
        .IN1              (IN1),
        .ENB              (ENB),
        .IN3              (IN3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       hl[$], hr[$];     // sensor value present at each edge since release
    int       n = 0;
    bit       fl = 0, fr = 0;
    int       st = M_STOP;
    int       run = 0;
    bit [3:0] exp_o = 4'b0;     // {ENA, IN1, ENB, IN3}

    // Input seen at edge k (0 before release, as the synchronizer resets to 0).
    function automatic bit past(bit side, int k);
        if (k < 1) return 1'b0;
        return side ? hr[k-1] : hl[k-1];
    endfunction

    // A filtered value changes once the synchronized input (2 edges old) has
    // held a new value for D consecutive edges.
    function automatic bit filt_upd(bit side, bit cur);
        bit v;
        v = past(side, n - 2);
        for (int j = 0; j < D; j++)
            if (past(side, n - 2 - j) != v) return cur;
        return v;
    endfunction

    function automatic int duty_a(int s);
        return (s == M_FWD) ? FWD : (s == M_RIGHT) ? TURN : 0;
    endfunction
    function automatic int duty_b(int s);
        return (s == M_FWD) ? FWD : (s == M_LEFT) ? TURN : 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                hl.delete(); hr.delete();
                n = 0; fl = 0; fr = 0; st = M_STOP; run = 0; exp_o = 4'b0;
            end else begin
                n++;
                hl.push_back(sl);
                hr.push_back(sr);
                fl = filt_upd(1'b0, fl);
                fr = filt_upd(1'b1, fr);
                exp_o = {(((n - 1) % 256) < duty_a(st)),
                         (st == M_FWD || st == M_RIGHT),
                         (((n - 1) % 256) < duty_b(st)),
                         (st == M_FWD || st == M_LEFT)};
                if (fl && fr) begin
                    run++;
                    if (run >= SC) st = M_STOP;
                end else begin
                    run = 0;
                    st = fl ? M_LEFT : fr ? M_RIGHT : M_FWD;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cycle", {ENA, IN1, ENB, IN3}, exp_o);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic duty_count(output int ca, output int cb);
        ca = 0; cb = 0;
        repeat (256) begin
            @(negedge clk);
            ca += int'(ENA);
            cb += int'(ENB);
        end
        step(1);
    endtask

    int ca, cb;

    initial begin
        // Reset hold with (1,0) applied
        sl = 1; sr = 0; reset = 0;
        repeat (5) @(posedge clk);
        #2 chk("reset_hold", {ENA, IN1, ENB, IN3}, 4'b0000);
        sl = 0; reset = 1;
        step(1);
        chk("first_edge_out", {ENA, IN1, ENB, IN3}, 4'b0000);
        step(1);
        chk("fwd_dir", {IN1, IN3}, 2'b11);
        duty_count(ca, cb);
        chk("fwd_duty_a", ca, FWD);
        chk("fwd_duty_b", cb, FWD);

        // Turn left, latency pinned to 3 + D edges
        sl = 1;
        step(6);
        chk("left_lat_early", IN1, 1);
        step(1);
        chk("left_in1", {IN1, IN3}, 2'b01);
        duty_count(ca, cb);
        chk("left_duty_a", ca, 0);
        chk("left_duty_b", cb, TURN);

        // Turn right
        sl = 0; sr = 1;
        step(7);
        chk("right_dir", {IN1, IN3}, 2'b10);
        duty_count(ca, cb);
        chk("right_duty_a", ca, TURN);
        chk("right_duty_b", cb, 0);

        // Glitch rejection
        sr = 0;
        step(10);
        sl = 1; step(2); sl = 0;
        step(12);
        chk("glitch_in1", {IN1, IN3}, 2'b11);

        // Short (1,1) holds the previous state
        sl = 1; step(10);
        sr = 1; step(10);
        chk("hold_left", {IN1, IN3}, 2'b01);
        sl = 0; sr = 0; step(10);
        chk("back_fwd", {IN1, IN3}, 2'b11);

        // Long (1,1): STOP lands exactly STOP_CONFIRM after the filter settles
        sl = 1; sr = 1;
        step(21);
        chk("stop_not_yet", {IN1, IN3}, 2'b11);
        step(1);
        chk("stop_entered", {ENA, IN1, ENB, IN3}, 4'b0000);
        step(8);
        chk("stop_held", {ENA, IN1, ENB, IN3}, 4'b0000);
        sl = 0; sr = 0;
        step(7);
        chk("stop_exit", {IN1, IN3}, 2'b11);

        // Asynchronous reset between edges
        step(20);
        chk("pre_rst", {IN1, IN3}, 2'b11);
        @(posedge clk);
        #3 reset = 0;
        #1 chk("async_rst", {ENA, IN1, ENB, IN3}, 4'b0000);
        step(3);
        reset = 1;
        step(10);
        chk("post_rst", {IN1, IN3}, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
